// File: rtl/tetris_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tetris_ctrl_unit
// Purpose  : Control and decode core of the tetris game.
//            - Moore FSM sequencing load / drop / commit / line clear / over.
//            - Combinational tetromino decode: centre, type and rotation in,
//              four cell coordinates out.
//            - Lowest-set-bit encoder picking the full row to clear.
// Ports    : clock, resetn (sync, active low)
//            start_game, filled_under, overflow, completed_lines[ROWS]  -> FSM
//            x[4], y[5], block_type[3], rotation[3]                    -> decode
//            block{1..4}_x[4], block{1..4}_y[5]                         decode out
//            load_block, drop_block, update_board_state, shift_down,
//            game_over                                                  commands
//            cleared_index[5]                                  lowest full row
// Revision : 1.0  initial release
// ============================================================================
module tetris_ctrl_unit #(
    parameter int ROWS     = 20,
    parameter int NONE_IDX = 20
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start_game,
    input  logic            filled_under,
    input  logic            overflow,
    input  logic [ROWS-1:0] completed_lines,
    input  logic [3:0]      x,
    input  logic [4:0]      y,
    input  logic [2:0]      block_type,
    input  logic [2:0]      rotation,
    output logic [3:0]      block1_x,
    output logic [4:0]      block1_y,
    output logic [3:0]      block2_x,
    output logic [4:0]      block2_y,
    output logic [3:0]      block3_x,
    output logic [4:0]      block3_y,
    output logic [3:0]      block4_x,
    output logic [4:0]      block4_y,
    output logic            load_block,
    output logic            drop_block,
    output logic            update_board_state,
    output logic            shift_down,
    output logic            game_over,
    output logic [4:0]      cleared_index
);

    // ------------------------------------------------------------------
    // Game sequencing FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DROP   = 3'd2,
        S_UPDATE = 3'd3,
        S_CHECK  = 3'd4,
        S_SHIFT  = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        load_block         = 1'b0;
        drop_block         = 1'b0;
        update_board_state = 1'b0;
        shift_down         = 1'b0;
        game_over          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_game) state_next = S_LOAD;
            end
            S_LOAD: begin
                load_block = 1'b1;
                state_next = S_DROP;
            end
            S_DROP: begin
                drop_block = 1'b1;
                if (filled_under) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                update_board_state = 1'b1;
                state_next         = S_CHECK;
            end
            S_CHECK: begin
                // Clearing lines wins over overflow: a clear may pull the
                // offending cells back below the visible limit.
                if (completed_lines != '0) state_next = S_SHIFT;
                else if (overflow)         state_next = S_OVER;
                else                       state_next = S_LOAD;
            end
            S_SHIFT: begin
                // Return to CHECK so rows are re-evaluated after the shift.
                shift_down = 1'b1;
                state_next = S_CHECK;
            end
            S_OVER: begin
                game_over = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lowest completed row; scanning downward lets the lowest index win.
    // ------------------------------------------------------------------
    always_comb begin
        cleared_index = 5'(NONE_IDX);
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (completed_lines[i]) cleared_index = 5'(i);
        end
    end

    // ------------------------------------------------------------------
    // Tetromino decode
    // ------------------------------------------------------------------
    logic signed [2:0] d2x, d2y, d3x, d3y, d4x, d4y;
    logic        [5:0] r2, r3, r4;
    logic        [1:0] rot_eff;
    logic              unused_rotation_msb;

    assign unused_rotation_msb = rotation[2];

    // Clockwise quarter turns: (dx,dy) -> (dy,-dx), applied r times.
    function automatic logic [5:0] rot_off(input logic [1:0] r,
                                           input logic signed [2:0] dx,
                                           input logic signed [2:0] dy);
        logic signed [2:0] ox, oy;
        case (r)
            2'd0:    begin ox = dx;  oy = dy;  end
            2'd1:    begin ox = dy;  oy = -dx; end
            2'd2:    begin ox = -dx; oy = -dy; end
            default: begin ox = -dy; oy = dx;  end
        endcase
        return {ox, oy};
    endfunction

    always_comb begin
        d2x = -3'sd1; d2y = 3'sd0;
        d3x =  3'sd1; d3y = 3'sd0;
        d4x =  3'sd2; d4y = 3'sd0;
        case (block_type)
            3'd1: begin d2x =  3'sd1; d2y = 3'sd0; d3x = 3'sd0; d3y = -3'sd1; d4x =  3'sd1; d4y = -3'sd1; end
            3'd2: begin d2x = -3'sd1; d2y = 3'sd0; d3x = 3'sd1; d3y =  3'sd0; d4x =  3'sd0; d4y =  3'sd1; end
            3'd3: begin d2x = -3'sd1; d2y = 3'sd0; d3x = 3'sd0; d3y =  3'sd1; d4x =  3'sd1; d4y =  3'sd1; end
            3'd4: begin d2x =  3'sd1; d2y = 3'sd0; d3x = 3'sd0; d3y =  3'sd1; d4x = -3'sd1; d4y =  3'sd1; end
            3'd5: begin d2x = -3'sd1; d2y = 3'sd0; d3x = 3'sd1; d3y =  3'sd0; d4x = -3'sd1; d4y =  3'sd1; end
            3'd6: begin d2x = -3'sd1; d2y = 3'sd0; d3x = 3'sd1; d3y =  3'sd0; d4x =  3'sd1; d4y =  3'sd1; end
            default: begin end  // types 0 and 7: I piece
        endcase
    end

    // The O piece is rotation-invariant.
    assign rot_eff = (block_type == 3'd1) ? 2'd0 : rotation[1:0];

    assign r2 = rot_off(rot_eff, d2x, d2y);
    assign r3 = rot_off(rot_eff, d3x, d3y);
    assign r4 = rot_off(rot_eff, d4x, d4y);

    // Offsets are sign-extended and added modulo the field width so that
    // underflow wraps; the datapath's bounds check depends on the wrap.
    assign block1_x = x;
    assign block1_y = y;
    assign block2_x = x + {r2[5], r2[5:3]};
    assign block2_y = y + {{2{r2[2]}}, r2[2:0]};
    assign block3_x = x + {r3[5], r3[5:3]};
    assign block3_y = y + {{2{r3[2]}}, r3[2:0]};
    assign block4_x = x + {r4[5], r4[5:3]};
    assign block4_y = y + {{2{r4[2]}}, r4[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_tetris_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_ctrl_unit
// Purpose  : Self-checking bench for tetris_ctrl_unit. Expected values are
//            queued when stimulus is applied and popped when the DUT output
//            is sampled (#1 after the rising edge, or #1 after a decode input
//            change).
// Revision : 1.0  initial release
// ============================================================================
module tb_tetris_ctrl_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start_game;
    logic        filled_under;
    logic        overflow;
    logic [19:0] completed_lines;
    logic [3:0]  x;
    logic [4:0]  y;
    logic [2:0]  block_type;
    logic [2:0]  rotation;
    logic [3:0]  block1_x, block2_x, block3_x, block4_x;
    logic [4:0]  block1_y, block2_y, block3_y, block4_y;
    logic        load_block, drop_block, update_board_state, shift_down, game_over;
    logic [4:0]  cleared_index;

    int checks = 0;
    int errors = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    tetris_ctrl_unit #(.ROWS(20), .NONE_IDX(20)) dut (
        .clock              (clock),
        .resetn             (resetn),
        .start_game         (start_game),
        .filled_under       (filled_under),
        .overflow           (overflow),
        .completed_lines    (completed_lines),
        .x                  (x),
        .y                  (y),
        .block_type         (block_type),
        .rotation           (rotation),
        .block1_x           (block1_x),
        .block1_y           (block1_y),
        .block2_x           (block2_x),
        .block2_y           (block2_y),
        .block3_x           (block3_x),
        .block3_y           (block3_y),
        .block4_x           (block4_x),
        .block4_y           (block4_y),
        .load_block         (load_block),
        .drop_block         (drop_block),
        .update_board_state (update_board_state),
        .shift_down         (shift_down),
        .game_over          (game_over),
        .cleared_index      (cleared_index)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, obs, e);
    endtask

    function automatic logic [63:0] cmds();
        return {59'd0, load_block, drop_block, update_board_state, shift_down, game_over};
    endfunction

    // Command vector order: {load, drop, update, shift, over}
    task automatic step(input string tag, input logic [4:0] exp_cmd);
        sb_push(tag, {59'd0, exp_cmd});
        @(posedge clock);
        #1;
        sb_pop(cmds());
    endtask

    task automatic idx_chk(input string tag, input logic [4:0] exp_idx);
        sb_push(tag, {59'd0, exp_idx});
        #1;
        sb_pop({59'd0, cleared_index});
    endtask

    task automatic dec(input string tag, input logic [2:0] t, input logic [3:0] cx,
                       input logic [4:0] cy, input logic [2:0] r,
                       input logic [3:0] e2x, input logic [4:0] e2y,
                       input logic [3:0] e3x, input logic [4:0] e3y,
                       input logic [3:0] e4x, input logic [4:0] e4y);
        block_type = t; x = cx; y = cy; rotation = r;
        sb_push(tag, {28'd0, cx, cy, e2x, e2y, e3x, e3y, e4x, e4y});
        #1;
        sb_pop({28'd0, block1_x, block1_y, block2_x, block2_y,
                block3_x, block3_y, block4_x, block4_y});
    endtask

    initial begin
        resetn = 1'b0; start_game = 1'b0; filled_under = 1'b0; overflow = 1'b0;
        completed_lines = '0; x = 4'd0; y = 5'd0; block_type = 3'd0; rotation = 3'd0;
        #1;

        // Reset and idle
        step("reset0", 5'b00000);
        step("reset1", 5'b00000);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step("idle_hold", 5'b00000);
        idx_chk("idx_none", 5'd20);

        // Start -> LOAD -> DROP, drop held while not resting
        start_game = 1'b1;
        step("load", 5'b10000);
        start_game = 1'b0;
        step("drop", 5'b01000);
        for (int i = 0; i < 5; i++) step("drop_hold", 5'b01000);
        filled_under = 1'b1;
        step("update", 5'b00100);
        filled_under = 1'b0;
        step("check0", 5'b00000);
        step("reload", 5'b10000);

        // Line clearing, including priority over overflow
        step("drop2", 5'b01000);
        filled_under = 1'b1;
        step("update2", 5'b00100);
        filled_under = 1'b0;
        completed_lines = 20'h00024;
        step("check_a", 5'b00000);
        idx_chk("idx_2", 5'd2);
        step("shift_a", 5'b00010);
        completed_lines = 20'h00020;
        overflow = 1'b1;
        step("check_b", 5'b00000);
        idx_chk("idx_5", 5'd5);
        step("shift_prio", 5'b00010);
        completed_lines = 20'h80000;
        idx_chk("idx_19", 5'd19);
        completed_lines = '0;
        overflow = 1'b0;
        step("check_c", 5'b00000);
        step("load_after_clear", 5'b10000);

        // Overflow -> game over, sticky until reset
        step("drop3", 5'b01000);
        filled_under = 1'b1;
        step("update3", 5'b00100);
        filled_under = 1'b0;
        overflow = 1'b1;
        step("check_d", 5'b00000);
        step("over", 5'b00001);
        start_game = 1'b1;
        for (int i = 0; i < 10; i++) step("over_hold", 5'b00001);
        resetn = 1'b0;
        step("over_reset", 5'b00000);
        resetn = 1'b1; start_game = 1'b0; overflow = 1'b0;
        step("idle_after", 5'b00000);

        // Tetromino decode
        dec("T_r0", 3'd2, 4'd4, 5'd19, 3'd0, 4'd3, 5'd19, 4'd5, 5'd19, 4'd4, 5'd20);
        dec("T_r1", 3'd2, 4'd4, 5'd19, 3'd1, 4'd4, 5'd20, 4'd4, 5'd18, 4'd5, 5'd19);
        dec("T_r2", 3'd2, 4'd4, 5'd19, 3'd2, 4'd5, 5'd19, 4'd3, 5'd19, 4'd4, 5'd18);
        dec("T_r3", 3'd2, 4'd4, 5'd19, 3'd3, 4'd4, 5'd18, 4'd4, 5'd20, 4'd3, 5'd19);
        dec("T_r5", 3'd2, 4'd4, 5'd19, 3'd5, 4'd4, 5'd20, 4'd4, 5'd18, 4'd5, 5'd19);
        dec("I_wrap", 3'd0, 4'd0, 5'd0, 3'd0, 4'd15, 5'd0, 4'd1, 5'd0, 4'd2, 5'd0);
        dec("I_r1", 3'd0, 4'd5, 5'd5, 3'd1, 4'd5, 5'd6, 4'd5, 5'd4, 4'd5, 5'd3);
        dec("O_r2", 3'd1, 4'd2, 5'd20, 3'd2, 4'd3, 5'd20, 4'd2, 5'd19, 4'd3, 5'd19);
        dec("O_ywrap", 3'd1, 4'd2, 5'd0, 3'd0, 4'd3, 5'd0, 4'd2, 5'd31, 4'd3, 5'd31);
        dec("S_r0", 3'd3, 4'd5, 5'd5, 3'd0, 4'd4, 5'd5, 4'd5, 5'd6, 4'd6, 5'd6);
        dec("Z_r1", 3'd4, 4'd5, 5'd5, 3'd1, 4'd5, 5'd4, 4'd6, 5'd5, 4'd6, 5'd6);
        dec("J_r0", 3'd5, 4'd5, 5'd5, 3'd0, 4'd4, 5'd5, 4'd6, 5'd5, 4'd4, 5'd6);
        dec("L_r3", 3'd6, 4'd5, 5'd5, 3'd3, 4'd5, 5'd4, 4'd5, 5'd6, 4'd4, 5'd6);
        dec("T7_r0", 3'd7, 4'd5, 5'd5, 3'd0, 4'd4, 5'd5, 4'd6, 5'd5, 4'd7, 5'd5);

        if (tag_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", tag_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tetris_ctrl_unit.md
Name: tetris_ctrl_unit

Overview:
Control and decode core of the tetris game; it sits between the datapath (board register file, piece position) and the game clocks. It contains three parts:
- A Moore state machine that sequences the game: load piece, drop, commit to board, clear lines, game over.
- Purely combinational tetromino decode, turning centre (x,y), type and rotation into four cell coordinates.
- A lowest-set-bit encoder that selects the full row to clear.

Parameters:
- ROWS, 20, number of visible rows checked for completion (width of completed_lines).
- NONE_IDX, 20, value driven on cleared_index when no row is complete.

Ports:
- clock  in  1  FSM clock (game-step tick).
- resetn  in  1  synchronous active-low reset.
- start_game  in  1  leaves IDLE when high.
- filled_under  in  1  current piece is resting on floor or on a fixed cell.
- overflow  in  1  a fixed cell exists in rows 20..22.
- completed_lines  in  ROWS  bit r high = row r full (row 0 = bottom).
- x  in  4  piece centre column.
- y  in  5  piece centre row (y grows upward).
- block_type  in  3  tetromino type 0..7.
- rotation  in  3  rotation step; only rotation[1:0] is used.
- block1_x..block4_x  out  4 each  cell columns.
- block1_y..block4_y  out  5 each  cell rows.
- load_block, drop_block, update_board_state, shift_down, game_over  out  1 each  datapath commands.
- cleared_index  out  5  index of the lowest completed row.

Behaviour:
- Only clock is used. Reset is synchronous and active-low (resetn sampled on posedge clock). Reset forces state IDLE and all five command outputs to 0.
- Command outputs are Moore outputs decoded from the state. At most one is high in any state.
- States and transitions, each step one clock:
  - IDLE: all commands 0. Goes to LOAD when start_game=1, else stays.
  - LOAD: load_block=1. Always goes to DROP.
  - DROP: drop_block=1. Goes to UPDATE if filled_under=1, else stays.
  - UPDATE: update_board_state=1. Always goes to CHECK.
  - CHECK: all commands 0.
    - If completed_lines≠0, go to SHIFT.
    - Else if overflow=1, go to OVER.
    - Else go to LOAD.
    - Line clearing has priority over overflow.
  - SHIFT: shift_down=1. Always goes to CHECK, which gives the datapath a cycle to update before rows are re-evaluated.
  - OVER: game_over=1. Held until reset; start_game is ignored.
- cleared_index is combinational: the smallest r with completed_lines[r]=1. When none is set it is NONE_IDX (20).
- Tetromino decode is combinational with zero latency and is unaffected by reset.
  - Block1 is always the centre (x,y).
  - Blocks 2..4 are centre plus offsets (dx,dy).
  - Rotation-0 offsets for blocks 2, 3, 4:
    - type 0 (I): (-1,0), (1,0), (2,0)
    - type 1 (O): (1,0), (0,-1), (1,-1)
    - type 2 (T): (-1,0), (1,0), (0,1)
    - type 3 (S): (-1,0), (0,1), (1,1)
    - type 4 (Z): (1,0), (0,1), (-1,1)
    - type 5 (J): (-1,0), (1,0), (-1,1)
    - type 6 (L): (-1,0), (1,0), (1,1)
    - type 7: identical to type 0.
  - Rotation r = rotation[1:0] applies clockwise (dx,dy)→(dy,-dx) r times.
  - Exception: type 1 (O) ignores rotation.
  - Addition is unsigned modulo 16 for x and modulo 32 for y. Underflow wraps (x=0, dx=-1 → 15), and the datapath's bounds check relies on this. No saturation.

Test Plan:
- resetn=0 for 2 clocks, then start_game=0 → all commands 0 and IDLE held. Pulse start_game=1 → load_block=1 next cycle, then drop_block=1.
- In DROP, hold filled_under=0 for 5 clocks → drop_block stays 1. Set filled_under=1 → update_board_state for 1 cycle, one idle cycle (CHECK), then load_block=1 (completed_lines=0, overflow=0).
- After UPDATE with completed_lines=20'h00024 → cleared_index=2 and shift_down=1 for 1 cycle. Change to 20'h00020 → cleared_index=5, shift_down again. Clear to 0 → load_block.
- completed_lines=0 with overflow=1 at CHECK → game_over=1 held for 10 clocks despite start_game=1. resetn=0 → game_over=0, IDLE.
- Decode T, x=4, y=19:
  - rot 0 → (4,19), (3,19), (5,19), (4,20).
  - rot 1 → block4 = (5,19).
  - rot 2 → block4 = (4,18).
  - rot 3 → block4 = (3,19).
  - rotation=3'd5 gives the same as rot 1.
- Decode I, x=0, y=0, rot 0 → block2_x=15. O at (2,20), rot 2 → (2,20), (3,20), (2,19), (3,19).
